// File: rtl/cache_input_stage_if.sv
// -----------------------------------------------------------------------------
// cache_input_stage_if
//   Bundles the request, TLB configuration, status and bank-side signals of
//   the data-cache input stage.
//
//   slave  : the input stage itself. It receives request and TLB fields and
//            drives status and even/odd bank fields.
//   master : the requester/bank side. It drives the request and observes
//            the results.
//
//   Request     : address_in, data_in, size_in, r, w, sw, valid_in,
//                 fromBUS, sizeOVR
//   TLB         : VP, PF (20 bits per entry), entry_V/P/RW/PCD
//   Status      : TLB_hit, TLB_miss, protection_exception, PCD_out (comb)
//   Registered  : oddIsGreater, needP1, oneSize, PCD_q, and for X in {E,O}
//                 vAddressX, addressX, dataX, sizeX, rX, wX, swX, validX,
//                 fromBUSX, maskX
// -----------------------------------------------------------------------------
interface cache_input_stage_if #(
    parameter int NTLB = 8
);
    logic [31:0]        address_in;
    logic [127:0]       data_in;
    logic [1:0]         size_in;
    logic               r;
    logic               w;
    logic               sw;
    logic               valid_in;
    logic               fromBUS;
    logic               sizeOVR;

    logic [20*NTLB-1:0] VP;
    logic [20*NTLB-1:0] PF;
    logic [NTLB-1:0]    entry_V;
    logic [NTLB-1:0]    entry_P;
    logic [NTLB-1:0]    entry_RW;
    logic [NTLB-1:0]    entry_PCD;

    logic               TLB_hit;
    logic               TLB_miss;
    logic               protection_exception;
    logic               PCD_out;

    logic               oddIsGreater;
    logic               needP1;
    logic [2:0]         oneSize;
    logic               PCD_q;

    logic [31:0]        vAddressE;
    logic [14:0]        addressE;
    logic [127:0]       dataE;
    logic [1:0]         sizeE;
    logic               rE;
    logic               wE;
    logic               swE;
    logic               validE;
    logic               fromBUSE;
    logic [127:0]       maskE;

    logic [31:0]        vAddressO;
    logic [14:0]        addressO;
    logic [127:0]       dataO;
    logic [1:0]         sizeO;
    logic               rO;
    logic               wO;
    logic               swO;
    logic               validO;
    logic               fromBUSO;
    logic [127:0]       maskO;

    modport slave (
        input  address_in, data_in, size_in, r, w, sw, valid_in, fromBUS, sizeOVR,
        input  VP, PF, entry_V, entry_P, entry_RW, entry_PCD,
        output TLB_hit, TLB_miss, protection_exception, PCD_out,
        output oddIsGreater, needP1, oneSize, PCD_q,
        output vAddressE, addressE, dataE, sizeE, rE, wE, swE, validE, fromBUSE, maskE,
        output vAddressO, addressO, dataO, sizeO, rO, wO, swO, validO, fromBUSO, maskO
    );

    modport master (
        output address_in, data_in, size_in, r, w, sw, valid_in, fromBUS, sizeOVR,
        output VP, PF, entry_V, entry_P, entry_RW, entry_PCD,
        input  TLB_hit, TLB_miss, protection_exception, PCD_out,
        input  oddIsGreater, needP1, oneSize, PCD_q,
        input  vAddressE, addressE, dataE, sizeE, rE, wE, swE, validE, fromBUSE, maskE,
        input  vAddressO, addressO, dataO, sizeO, rO, wO, swO, validO, fromBUSO, maskO
    );
endinterface

// File: rtl/cache_input_stage.sv
// -----------------------------------------------------------------------------
// cache_input_stage
//   Front end of the split even/odd data cache. It takes one virtual request
//   and translates it through a small fully-associative TLB (15-bit physical
//   space). A request that crosses a cache line is split into two line
//   requests, each with a byte mask and aligned data. The two lanes are
//   steered to the even or odd bank by physical line parity and registered
//   for the banks.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous active-low reset; clears every registered output
//     bus  : cache_input_stage_if.slave. The request and TLB fields are
//            inputs. TLB_hit, TLB_miss, protection_exception and PCD_out are
//            combinational outputs. The bank fields plus oddIsGreater,
//            needP1, oneSize and PCD_q are registered with 1-cycle latency.
// -----------------------------------------------------------------------------
module cache_input_stage #(
    parameter int NTLB  = 8,
    parameter int LINEB = 16
) (
    input logic                clk,
    input logic                rst,
    cache_input_stage_if.slave bus
);
    localparam int OFFW = $clog2(LINEB);   // byte offset within a line
    localparam int CNTW = OFFW + 1;        // byte counts 0..LINEB
    localparam int IDXW = $clog2(NTLB);
    localparam int DW   = 8 * LINEB;

    typedef struct packed {
        logic            hit;
        logic [IDXW-1:0] idx;
        logic [2:0]      frame;
    } tlb_res_t;

    typedef struct packed {
        logic [31:0]   vaddr;
        logic [14:0]   paddr;
        logic [DW-1:0] data;
        logic [1:0]    size;
        logic          r;
        logic          w;
        logic          sw;
        logic          valid;
        logic          from_bus;
        logic [DW-1:0] mask;
    } lane_t;

    function automatic tlb_res_t tlb_lookup(
        input logic [19:0]        vpn,
        input logic [20*NTLB-1:0] vp,
        input logic [20*NTLB-1:0] pf,
        input logic [NTLB-1:0]    ev
    );
        tlb_res_t res;
        res = '0;
        // Scan from the top down so the lowest matching index is the one left.
        for (int i = NTLB - 1; i >= 0; i--) begin
            if (ev[i] && (vp[20*i +: 20] == vpn)) begin
                res.hit   = 1'b1;
                res.idx   = IDXW'(i);
                res.frame = pf[20*i +: 3];
            end
        end
        return res;
    endfunction

    // Turns per-byte enables into a per-bit mask.
    function automatic logic [DW-1:0] expand(input logic [LINEB-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < LINEB; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    logic [CNTW-1:0] nbytes;
    logic [OFFW-1:0] off;
    logic [CNTW:0]   end_pos;
    logic            split;
    logic [CNTW-1:0] b0;
    logic [CNTW-1:0] b1;
    logic [31:0]     vaddr0;
    logic [31:0]     vaddr1;
    tlb_res_t        res0;
    tlb_res_t        res1;
    logic            need;
    logic            tlb_hit;
    logic            bad0;
    logic            bad1;
    logic            prot;
    logic            pcd;
    logic            lane_ok;
    logic [LINEB:0]  be0_wide;
    logic [LINEB:0]  be1_wide;
    logic [LINEB-1:0] be0;
    logic [LINEB-1:0] be1;
    lane_t           lane0;
    lane_t           lane1;
    lane_t           bank_e_d;
    lane_t           bank_o_d;
    logic            odd_d;
    logic [2:0]      one_d;

    lane_t           bank_e_q;
    lane_t           bank_o_q;
    logic            odd_q;
    logic            need_q;
    logic [2:0]      one_q;
    logic            pcd_q;

    // NOTE: every signal written here gets a default at the top of the block,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        nbytes   = (bus.fromBUS | bus.sizeOVR) ? CNTW'(LINEB) : (CNTW'(1) << bus.size_in);
        // A line fill always moves the whole line, so its offset is ignored.
        off      = bus.fromBUS ? '0 : bus.address_in[OFFW-1:0];
        end_pos  = (CNTW+1)'(off) + (CNTW+1)'(nbytes);
        split    = end_pos > (CNTW+1)'(LINEB);
        b0       = split ? (CNTW'(LINEB) - CNTW'(off)) : nbytes;
        b1       = nbytes - b0;
        need     = bus.valid_in & split;

        vaddr0   = bus.fromBUS ? {bus.address_in[31:OFFW], {OFFW{1'b0}}} : bus.address_in;
        vaddr1   = {vaddr0[31:OFFW] + (32-OFFW)'(1), {OFFW{1'b0}}};

        res0     = tlb_lookup(vaddr0[31:12], bus.VP, bus.PF, bus.entry_V);
        res1     = tlb_lookup(vaddr1[31:12], bus.VP, bus.PF, bus.entry_V);

        tlb_hit  = bus.valid_in & res0.hit & (~need | res1.hit);
        bad0     = ~bus.entry_P[res0.idx] | ((bus.w | bus.sw) & ~bus.entry_RW[res0.idx]);
        bad1     = ~bus.entry_P[res1.idx] | ((bus.w | bus.sw) & ~bus.entry_RW[res1.idx]);
        prot     = tlb_hit & ~bus.fromBUS & (bad0 | (need & bad1));
        pcd      = (bus.valid_in & res0.hit & bus.entry_PCD[res0.idx])
                 | (need & res1.hit & bus.entry_PCD[res1.idx]);
        lane_ok  = tlb_hit & ~prot;

        // A run of b ones: (1 << b) - 1, computed one bit wider so b == LINEB works.
        be0_wide = ((LINEB+1)'(1) << b0) - (LINEB+1)'(1);
        be1_wide = ((LINEB+1)'(1) << b1) - (LINEB+1)'(1);
        be0      = be0_wide[LINEB-1:0] << off;
        be1      = be1_wide[LINEB-1:0];

        lane0          = '0;
        lane0.vaddr    = vaddr0;
        lane0.paddr    = {res0.frame, vaddr0[11:0]};
        lane0.data     = bus.data_in << {off, 3'b000};
        lane0.size     = bus.size_in;
        lane0.r        = bus.r;
        lane0.w        = bus.w;
        lane0.sw       = bus.sw;
        lane0.valid    = lane_ok;
        lane0.from_bus = bus.fromBUS;
        lane0.mask     = lane_ok ? expand(be0) : '0;

        // The second lane continues with the payload bytes lane 0 did not take.
        lane1          = '0;
        lane1.vaddr    = vaddr1;
        lane1.paddr    = {res1.frame, vaddr1[11:0]};
        lane1.data     = bus.data_in >> {b0, 3'b000};
        lane1.size     = bus.size_in;
        lane1.r        = bus.r;
        lane1.w        = bus.w;
        lane1.sw       = bus.sw;
        lane1.valid    = lane_ok & need;
        lane1.from_bus = bus.fromBUS;
        lane1.mask     = (lane_ok & need) ? expand(be1) : '0;

        // Physical line parity of lane 0 chooses its bank; lane 1 takes the other.
        bank_e_d = lane0;
        bank_o_d = lane1;
        if (lane0.paddr[OFFW]) begin
            bank_e_d = lane1;
            bank_o_d = lane0;
        end
        odd_d = bus.valid_in & ~lane0.paddr[OFFW];
        one_d = need ? b0[2:0] : 3'd0;
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_e_q <= '0;
            bank_o_q <= '0;
            odd_q    <= 1'b0;
            need_q   <= 1'b0;
            one_q    <= 3'd0;
            pcd_q    <= 1'b0;
        end else begin
            bank_e_q <= bank_e_d;
            bank_o_q <= bank_o_d;
            odd_q    <= odd_d;
            need_q   <= need;
            one_q    <= one_d;
            pcd_q    <= pcd;
        end
    end

    assign bus.TLB_hit              = tlb_hit;
    assign bus.TLB_miss             = bus.valid_in & ~tlb_hit;
    assign bus.protection_exception = prot;
    assign bus.PCD_out              = pcd;

    assign bus.oddIsGreater = odd_q;
    assign bus.needP1       = need_q;
    assign bus.oneSize      = one_q;
    assign bus.PCD_q        = pcd_q;

    assign bus.vAddressE = bank_e_q.vaddr;
    assign bus.addressE  = bank_e_q.paddr;
    assign bus.dataE     = bank_e_q.data;
    assign bus.sizeE     = bank_e_q.size;
    assign bus.rE        = bank_e_q.r;
    assign bus.wE        = bank_e_q.w;
    assign bus.swE       = bank_e_q.sw;
    assign bus.validE    = bank_e_q.valid;
    assign bus.fromBUSE  = bank_e_q.from_bus;
    assign bus.maskE     = bank_e_q.mask;

    assign bus.vAddressO = bank_o_q.vaddr;
    assign bus.addressO  = bank_o_q.paddr;
    assign bus.dataO     = bank_o_q.data;
    assign bus.sizeO     = bank_o_q.size;
    assign bus.rO        = bank_o_q.r;
    assign bus.wO        = bank_o_q.w;
    assign bus.swO       = bank_o_q.sw;
    assign bus.validO    = bank_o_q.valid;
    assign bus.fromBUSO  = bank_o_q.from_bus;
    assign bus.maskO     = bank_o_q.mask;
endmodule

// File: tb/tb_cache_input_stage.sv
// -----------------------------------------------------------------------------
// tb_cache_input_stage
//   Directed steps followed by random requests. Expected values come from a
//   byte-level reference model: each payload byte is placed in its line and
//   lane, and then the lanes are steered by line parity.
// -----------------------------------------------------------------------------
module tb_cache_input_stage;
    logic clk;
    logic rst;

    cache_input_stage_if #(.NTLB(8)) bus ();

    cache_input_stage #(.NTLB(8), .LINEB(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0]  a;
        logic [127:0] d;
        logic [1:0]   sz;
        logic         r, w, sw, v, fb, ovr;
    } req_t;

    typedef struct {
        logic         valid;
        logic [31:0]  vaddr;
        logic [14:0]  addr;
        logic [127:0] data;
        logic [127:0] mask;
        logic [1:0]   size;
        logic         r, w, sw, fb;
    } bank_t;

    typedef struct {
        logic       hit, miss, prot, pcd, need, odd, ok;
        logic [2:0] one;
        bank_t      e, o;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] vp_tab [8];
    logic [19:0] pf_tab [8];
    logic [7:0]  ev, ep, erw, epcd;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_tlb();
        for (int i = 0; i < 8; i++) begin
            bus.VP[20*i +: 20] = vp_tab[i];
            bus.PF[20*i +: 20] = pf_tab[i];
        end
        bus.entry_V   = ev;
        bus.entry_P   = ep;
        bus.entry_RW  = erw;
        bus.entry_PCD = epcd;
    endtask

    // Returns the lowest valid entry whose tag matches, or -1.
    function automatic int find(input logic [31:0] va);
        for (int i = 0; i < 8; i++)
            if (ev[i] && vp_tab[i] == va[31:12]) return i;
        return -1;
    endfunction

    function automatic bit perm_bad(input int i, input req_t q);
        return !ep[i] || ((q.w || q.sw) && !erw[i]);
    endfunction

    function automatic exp_t model(input req_t q);
        exp_t  m;
        bank_t l0, l1;
        int    n, off, b0, b1, i0, i1;
        logic [31:0] base0, base1;
        logic [14:0] pa0;
        n     = (q.fb || q.ovr) ? 16 : (1 << q.sz);
        off   = q.fb ? 0 : int'(q.a[3:0]);
        base0 = q.fb ? (q.a & ~32'hF) : q.a;
        base1 = (base0 & ~32'hF) + 32'd16;
        b0    = (off + n > 16) ? 16 - off : n;
        b1    = n - b0;
        i0    = find(base0);
        i1    = find(base1);
        m.need = q.v && (b1 > 0);
        m.hit  = q.v && (i0 >= 0) && (!m.need || i1 >= 0);
        m.miss = q.v && !m.hit;
        m.prot = m.hit && !q.fb && (perm_bad(i0, q) || (m.need && perm_bad(i1, q)));
        m.pcd  = (q.v && i0 >= 0 && epcd[i0]) || (m.need && i1 >= 0 && epcd[i1]);
        m.ok   = m.hit && !m.prot;
        m.one  = m.need ? 3'(b0) : 3'd0;

        l0 = '{valid: m.ok, vaddr: base0, addr: '0, data: '0, mask: '0,
               size: q.sz, r: q.r, w: q.w, sw: q.sw, fb: q.fb};
        l1 = '{valid: m.ok && m.need, vaddr: base1, addr: '0, data: '0, mask: '0,
               size: q.sz, r: q.r, w: q.w, sw: q.sw, fb: q.fb};
        if (i0 >= 0) l0.addr = {pf_tab[i0][2:0], base0[11:0]};
        if (i1 >= 0) l1.addr = {pf_tab[i1][2:0], base1[11:0]};
        for (int p = 0; p < 16; p++) begin
            if (p >= off)      l0.data[8*p +: 8] = q.d[8*(p-off) +: 8];
            if (p + b0 < 16)   l1.data[8*p +: 8] = q.d[8*(p+b0) +: 8];
            if (l0.valid && p >= off && p < off + b0) l0.mask[8*p +: 8] = 8'hFF;
            if (l1.valid && p < b1)                   l1.mask[8*p +: 8] = 8'hFF;
        end
        pa0   = l0.addr;
        m.odd = q.v && !pa0[4];
        if (!pa0[4]) begin m.e = l0; m.o = l1; end
        else         begin m.e = l1; m.o = l0; end
        return m;
    endfunction

    function automatic bank_t act_e();
        bank_t b;
        b = '{valid: bus.validE, vaddr: bus.vAddressE, addr: bus.addressE, data: bus.dataE,
              mask: bus.maskE, size: bus.sizeE, r: bus.rE, w: bus.wE, sw: bus.swE, fb: bus.fromBUSE};
        return b;
    endfunction

    function automatic bank_t act_o();
        bank_t b;
        b = '{valid: bus.validO, vaddr: bus.vAddressO, addr: bus.addressO, data: bus.dataO,
              mask: bus.maskO, size: bus.sizeO, r: bus.rO, w: bus.wO, sw: bus.swO, fb: bus.fromBUSO};
        return b;
    endfunction

    task automatic check_bank(input string tag, input bank_t x, input bank_t a, input bit with_mask);
        check({tag, ".valid"}, 128'(a.valid), 128'(x.valid));
        if (with_mask) check({tag, ".mask"}, a.mask, x.mask);
        if (x.valid) begin
            check({tag, ".vaddr"}, 128'(a.vaddr), 128'(x.vaddr));
            check({tag, ".addr"},  128'(a.addr),  128'(x.addr));
            check({tag, ".data"},  a.data, x.data);
            check({tag, ".size"},  128'(a.size),  128'(x.size));
            check({tag, ".rwsw"},  128'({a.r, a.w, a.sw, a.fb}), 128'({x.r, x.w, x.sw, x.fb}));
        end
    endtask

    // Drives one request at the falling edge, checks the combinational
    // status, and then checks the registered outputs just after the next
    // rising edge.
    task automatic run_req(input string tag, input req_t q);
        exp_t m;
        @(negedge clk);
        bus.address_in = q.a;
        bus.data_in    = q.d;
        bus.size_in    = q.sz;
        bus.r          = q.r;
        bus.w          = q.w;
        bus.sw         = q.sw;
        bus.valid_in   = q.v;
        bus.fromBUS    = q.fb;
        bus.sizeOVR    = q.ovr;
        m = model(q);
        #1;
        check({tag, ".hit"},  128'(bus.TLB_hit),              128'(m.hit));
        check({tag, ".miss"}, 128'(bus.TLB_miss),             128'(m.miss));
        check({tag, ".prot"}, 128'(bus.protection_exception), 128'(m.prot));
        check({tag, ".pcd"},  128'(bus.PCD_out),              128'(m.pcd));
        @(posedge clk);
        #1;
        check({tag, ".needP1"},  128'(bus.needP1),  128'(m.need));
        check({tag, ".oneSize"}, 128'(bus.oneSize), 128'(m.one));
        check({tag, ".PCD_q"},   128'(bus.PCD_q),   128'(m.pcd));
        if (m.ok || !q.v) check({tag, ".odd"}, 128'(bus.oddIsGreater), 128'(m.odd));
        check_bank({tag, ".E"}, m.e, act_e(), m.ok);
        check_bank({tag, ".O"}, m.o, act_o(), m.ok);
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic [1:0] sz, input logic r,
                                input logic w, input logic sw, input logic fb);
        req_t q;
        q = '{a: a, d: 128'h1111_2222_3333_4444_5555_6666_7777_8888, sz: sz,
              r: r, w: w, sw: sw, v: 1'b1, fb: fb, ovr: 1'b0};
        return q;
    endfunction

    initial begin
        req_t q;
        rst = 1'b1;
        vp_tab[0] = 20'h00000; vp_tab[1] = 20'h02000; vp_tab[2] = 20'h04000; vp_tab[3] = 20'h0b000;
        vp_tab[4] = 20'h0c000; vp_tab[5] = 20'h0a000; vp_tab[6] = 20'h06000; vp_tab[7] = 20'h03000;
        pf_tab[0] = 20'h00013; pf_tab[1] = 20'h00021; pf_tab[2] = 20'h00005; pf_tab[3] = 20'h00037;
        pf_tab[4] = 20'h00042; pf_tab[5] = 20'h00056; pf_tab[6] = 20'h00064; pf_tab[7] = 20'h00070;
        ev = 8'hBF; ep = 8'hF7; erw = 8'hD5; epcd = 8'h03;
        load_tlb();
        bus.address_in = '0; bus.data_in = '0; bus.size_in = '0;
        bus.r = 0; bus.w = 0; bus.sw = 0; bus.valid_in = 0; bus.fromBUS = 0; bus.sizeOVR = 0;

        // Step 1: reset clears all registered outputs, with or without a clock edge.
        #3 rst = 1'b0;
        #1;
        check("rst.validE", 128'(bus.validE), 128'd0);
        check("rst.validO", 128'(bus.validO), 128'd0);
        check("rst.maskE",  bus.maskE, 128'd0);
        check("rst.status", 128'({bus.needP1, bus.oneSize, bus.oddIsGreater, bus.PCD_q}), 128'd0);
        @(posedge clk); #1;
        check("rst.hold", 128'({bus.validE, bus.validO}), 128'd0);
        @(negedge clk) rst = 1'b1;

        q = mk(32'h0, 2'b00, 1, 0, 0, 0); q.v = 1'b0;
        run_req("idle", q);

        // Step 2: a 4-byte read with stack-write that crosses a line.
        run_req("split", mk(32'h0400000F, 2'b10, 1, 0, 1, 0));
        check("split.addrE", 128'(bus.addressE), 128'h500F);
        check("split.maskE", bus.maskE, {8'hFF, 120'd0});
        check("split.dataE", 128'(bus.dataE[127:120]), 128'h88);
        check("split.addrO", 128'(bus.addressO), 128'h5010);
        check("split.maskO", bus.maskO, 128'hFF_FFFF);
        check("split.dataO", 128'(bus.dataO[23:0]), 128'h77_7788);
        check("split.misc",  128'({bus.needP1, bus.oneSize, bus.oddIsGreater}), 128'({1'b1, 3'd1, 1'b1}));

        // Step 3: line fills to an even line and then an odd line.
        run_req("fill0", mk(32'h04000000, 2'b00, 0, 1, 0, 1));
        check("fill0.addrE", 128'(bus.addressE), 128'h5000);
        check("fill0.maskE", bus.maskE, {128{1'b1}});
        check("fill0.validO", 128'(bus.validO), 128'd0);
        q = mk(32'h04000010, 2'b00, 0, 1, 0, 1); q.d = {128{1'b1}};
        run_req("fill1", q);
        check("fill1.addrO", 128'({bus.validO, bus.addressO, bus.oddIsGreater}), 128'({1'b1, 15'h5010, 1'b0}));

        // Step 4: a matching tag with V=0 misses, and an absent tag misses.
        run_req("miss_v0", mk(32'h06000000, 2'b00, 1, 0, 0, 0));
        check("miss_v0.flag", 128'({bus.validE, bus.validO}), 128'd0);
        run_req("miss_none", mk(32'h01000000, 2'b00, 1, 0, 0, 0));

        // Step 5: not-present and read-only protection faults, then a legal read.
        run_req("prot_p", mk(32'h0B000000, 2'b00, 1, 0, 0, 0));
        run_req("prot_rw", mk(32'h02000000, 2'b00, 0, 1, 0, 0));
        run_req("prot_ok", mk(32'h02000000, 2'b00, 1, 0, 0, 0));

        // Step 6: an unsplit 8-byte read through a cache-disabled page.
        run_req("pcd8", mk(32'h00000004, 2'b11, 1, 0, 0, 0));
        check("pcd8.maskE", bus.maskE, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_0000_0000);
        check("pcd8.flags", 128'({bus.validO, bus.PCD_q}), 128'({1'b0, 1'b1}));

        // Duplicate tag: the lower index (entry 2) must win over entry 7.
        vp_tab[7] = 20'h04000; load_tlb();
        run_req("dup", mk(32'h04000100, 2'b00, 1, 0, 0, 0));
        check("dup.addrE", 128'(bus.addressE), 128'h5100);
        vp_tab[7] = 20'h03000; load_tlb();

        // Size boundaries: 8 bytes ending exactly at the line end, 8 bytes
        // one past it, and sizeOVR both aligned and misaligned.
        run_req("edge8", mk(32'h00000008, 2'b11, 1, 0, 0, 0));
        run_req("cross8", mk(32'h00000009, 2'b11, 1, 0, 0, 0));
        q = mk(32'h04000020, 2'b00, 1, 0, 0, 0); q.ovr = 1'b1;
        run_req("ovr_al", q);
        q = mk(32'h04000021, 2'b00, 1, 0, 0, 0); q.ovr = 1'b1;
        run_req("ovr_mis", q);

        // Random requests.
        for (int k = 0; k < 300; k++) begin
            logic [19:0] tag;
            logic [11:0] low;
            tag = ($urandom_range(0, 7) == 0) ? 20'($urandom) : vp_tab[$urandom_range(0, 7)];
            low = 12'($urandom);
            if ($urandom_range(0, 1) == 1) low[3:0] = 4'($urandom_range(9, 15));
            if ($urandom_range(0, 7) == 0) low[11:4] = 8'hFF;
            q.a   = {tag, low};
            q.d   = {$urandom, $urandom, $urandom, $urandom};
            q.sz  = 2'($urandom);
            q.r   = 1'($urandom);
            q.w   = 1'($urandom);
            q.sw  = 1'($urandom);
            q.v   = ($urandom_range(0, 7) != 0);
            q.fb  = ($urandom_range(0, 7) == 0);
            q.ovr = ($urandom_range(0, 7) == 0);
            run_req("rnd", q);
        end

        // Reset asserted mid-stream clears the registered outputs before any edge.
        run_req("pre_rst", mk(32'h00000004, 2'b11, 1, 0, 0, 0));
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst.valid", 128'({bus.validE, bus.validO}), 128'd0);
        check("async_rst.maskE", bus.maskE, 128'd0);
        check("async_rst.regs", 128'({bus.addressE, bus.PCD_q, bus.needP1}), 128'd0);
        check("async_rst.comb", 128'({bus.TLB_hit, bus.PCD_out}), 128'({1'b1, 1'b1}));
        @(posedge clk); #1;
        check("async_rst.hold", 128'({bus.validE, bus.validO}), 128'd0);
        @(negedge clk) rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
